// File: rtl/soc_testctl_pkg.sv
// Shared constants for the test-control slave: register map, result codes, CRC setup.
// Latency: n/a (constants only).
// Backpressure: n/a.
package soc_testctl_pkg;

    // Word offsets within the test-control window (byte addr[4:2])
    localparam logic [2:0] OFF_TOHOST    = 3'd0;
    localparam logic [2:0] OFF_CKPT      = 3'd1;
    localparam logic [2:0] OFF_SIG       = 3'd2;
    localparam logic [2:0] OFF_CYCLES    = 3'd3;
    localparam logic [2:0] OFF_EXPECT    = 3'd4;
    localparam logic [2:0] OFF_CHECK     = 3'd5;
    localparam logic [2:0] OFF_CKPT_LAST = 3'd6;

    // Result codes reported on test_code
    localparam logic [30:0] CODE_PASS       = 31'h0;
    localparam logic [30:0] CODE_CHECK_FAIL = 31'h7FFF_FFFE;
    localparam logic [30:0] CODE_TIMEOUT    = 31'h7FFF_FFFF;

    // Signature CRC: reflected CRC-32, no final XOR
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

endpackage

// File: rtl/soc_testctl_crc32_word.sv
// One full 32-bit CRC-32 step: folds a data word into the running signature, LSB first.
// Latency: purely combinational.
// Backpressure: none.
module soc_testctl_crc32_word
    import soc_testctl_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] data,
    output logic [31:0] crc_out
);

    // Bit-serial reflected CRC unrolled across all 32 data bits
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 32; i++) begin
            if (crc_out[0] ^ data[i]) begin
                crc_out = (crc_out >> 1) ^ CRC_POLY;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end

endmodule

// File: rtl/soc_testctl.sv
// Memory-mapped test-control/monitor slave: result posting, CRC signature, checkpoints, watchdog.
// Latency: writes take effect on the sampling edge; reads return registered data one cycle later.
// Backpressure: none; every selected beat is accepted in the cycle it is presented.
module soc_testctl
    import soc_testctl_pkg::*;
#(
    parameter logic [31:0] TIMEOUT = 32'd100000,
    parameter int          CKPT_W  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        test_done,
    output logic        test_pass,
    output logic [30:0] test_code,
    output logic        timeout
);

    logic [31:0]       sig;
    logic [31:0]       expect_val;
    logic [31:0]       cycles;
    logic [CKPT_W-1:0] ckpt_cnt;
    logic [31:0]       ckpt_last;
    logic [31:0]       sig_next;
    logic [31:0]       rd_mux;

    logic wr_beat, rd_beat;
    logic tohost_done, check_fail, cyc_clr, wdog_fire;

    assign wr_beat = sel & we;
    assign rd_beat = sel & ~we;

    // Completion sources, in priority order: TOHOST result, CHECK mismatch, watchdog.
    // A CYCLES clear on the would-be watchdog edge restarts the count instead of firing.
    assign tohost_done = wr_beat && (addr == OFF_TOHOST) && !test_done && wdata[0];
    assign check_fail  = wr_beat && (addr == OFF_CHECK) && !test_done && (sig != expect_val);
    assign cyc_clr     = wr_beat && (addr == OFF_CYCLES);
    assign wdog_fire   = !test_done && (cycles == TIMEOUT - 32'd1)
                         && !tohost_done && !check_fail && !cyc_clr;

    soc_testctl_crc32_word u_crc (
        .crc_in  (sig),
        .data    (wdata),
        .crc_out (sig_next)
    );

    // Sticky test status: first completion wins, later posts are ignored until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            test_done <= 1'b0;
            test_pass <= 1'b0;
            test_code <= CODE_PASS;
            timeout   <= 1'b0;
        end else if (tohost_done) begin
            test_done <= 1'b1;
            test_pass <= (wdata[31:1] == 31'h0);
            test_code <= wdata[31:1];
        end else if (check_fail) begin
            test_done <= 1'b1;
            test_pass <= 1'b0;
            test_code <= CODE_CHECK_FAIL;
        end else if (wdog_fire) begin
            test_done <= 1'b1;
            test_pass <= 1'b0;
            test_code <= CODE_TIMEOUT;
            timeout   <= 1'b1;
        end
    end

    // Saturating run-cycle counter, frozen once the test has finished
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles <= 32'h0;
        end else if (cyc_clr) begin
            cycles <= 32'h0;
        end else if (wdog_fire) begin
            cycles <= TIMEOUT;
        end else if (!test_done && (cycles != 32'hFFFF_FFFF)) begin
            cycles <= cycles + 32'd1;
        end
    end

    // Program-writable state: checkpoints, signature fold, expected signature
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ckpt_cnt   <= '0;
            ckpt_last  <= 32'h0;
            sig        <= CRC_INIT;
            expect_val <= 32'h0;
        end else if (wr_beat) begin
            if (addr == OFF_CKPT) begin
                if (ckpt_cnt != {CKPT_W{1'b1}}) begin
                    ckpt_cnt <= ckpt_cnt + CKPT_W'(1);
                end
                ckpt_last <= wdata;
            end
            if (addr == OFF_SIG) begin
                sig <= sig_next;
            end
            if (addr == OFF_EXPECT) begin
                expect_val <= wdata;
            end
        end
    end

    // Read decode; write-only and unused offsets return zero
    always_comb begin
        rd_mux = 32'h0;
        case (addr)
            OFF_CKPT:      rd_mux[CKPT_W-1:0] = ckpt_cnt;
            OFF_SIG:       rd_mux = sig;
            OFF_CYCLES:    rd_mux = cycles;
            OFF_EXPECT:    rd_mux = expect_val;
            OFF_CKPT_LAST: rd_mux = ckpt_last;
            default:       rd_mux = 32'h0;
        endcase
    end

    // Read data register: captured on a read beat, held until the next one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= 32'h0;
        end else if (rd_beat) begin
            rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_soc_testctl.sv
// Directed bench for soc_testctl: read responses are checked through an expectation queue.
// Latency: read data checked on the negedge after the sampling edge.
// Backpressure: none.
module tb_soc_testctl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        test_done;
    logic        test_pass;
    logic [30:0] test_code;
    logic        timeout;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_seen = 1'b0;

    soc_testctl #(.TIMEOUT(32'd50), .CKPT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .test_done (test_done),
        .test_pass (test_pass),
        .test_code (test_code),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Track which edges accepted a read beat
    always @(posedge clk or posedge reset) begin
        if (reset) rd_seen <= 1'b0;
        else       rd_seen <= sel && !we;
    end

    // Monitor: every accepted read pops one expectation and compares rdata
    always @(negedge clk) begin
        if (rd_seen) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_read rdata=%08h with no expectation queued", rdata);
            end else begin
                logic [31:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (rdata !== e) begin
                    failures = failures + 1;
                    $display("FAIL %s rdata=%08h expected=%08h", n, rdata, e);
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%08h expected=%08h", n, got, exp);
        end
    endtask

    task automatic chk_status(input string n, input logic d, input logic p,
                              input logic [30:0] c, input logic t);
        chk({n, "_done"},    {31'h0, test_done}, {31'h0, d});
        chk({n, "_pass"},    {31'h0, test_pass}, {31'h0, p});
        chk({n, "_code"},    {1'b0, test_code},  {1'b0, c});
        chk({n, "_timeout"}, {31'h0, timeout},   {31'h0, t});
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = a;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(negedge clk);
        sel = 1'b0;
    endtask

    // Pulse reset between edges; returns 2ns after a negedge
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        // Power-on reset, then a read presented on the very first edge sees cycles==0
        #12;
        sel = 1'b1; we = 1'b0; addr = 3'd3;
        exp_q.push_back(32'h0); name_q.push_back("cycles_first_edge");
        reset = 1'b0;
        @(negedge clk);
        sel = 1'b0;

        // Partial writes, then reset mid-run clears everything
        wr(3'd2, 32'h1234_5678);
        wr(3'd1, 32'h0000_00AA);
        wr(3'd4, 32'h5555_5555);
        rd(3'd4, 32'h5555_5555, "expect_before_reset");
        do_reset();
        chk("rdata_after_reset", rdata, 32'h0);
        chk_status("reset", 1'b0, 1'b0, 31'h0, 1'b0);
        rd(3'd2, 32'hFFFF_FFFF, "sig_after_reset");
        rd(3'd1, 32'h0, "ckpt_after_reset");
        rd(3'd6, 32'h0, "ckpt_last_after_reset");
        rd(3'd4, 32'h0, "expect_after_reset");

        // TOHOST pass, later post ignored
        do_reset();
        wr(3'd0, 32'h1);
        chk_status("tohost_pass", 1'b1, 1'b1, 31'h0, 1'b0);
        wr(3'd0, 32'hB);
        chk_status("tohost_sticky", 1'b1, 1'b1, 31'h0, 1'b0);

        // Even value ignored, then odd fail code
        do_reset();
        wr(3'd0, 32'h4);
        chk_status("tohost_even", 1'b0, 1'b0, 31'h0, 1'b0);
        wr(3'd0, 32'hB);
        chk_status("tohost_fail", 1'b1, 1'b0, 31'h5, 1'b0);

        // Signature fold and CHECK
        do_reset();
        wr(3'd2, 32'h0);
        rd(3'd2, 32'hDEBB_20E3, "sig_fold_zero");
        wr(3'd4, 32'hDEBB_20E3);
        rd(3'd4, 32'hDEBB_20E3, "expect_rw");
        wr(3'd5, 32'h0);
        chk_status("check_equal", 1'b0, 1'b0, 31'h0, 1'b0);
        wr(3'd4, 32'h0);
        wr(3'd5, 32'h0);
        chk_status("check_mismatch", 1'b1, 1'b0, 31'h7FFF_FFFE, 1'b0);

        // Folding all-ones into the initial value cancels to zero; zero then stays zero
        do_reset();
        wr(3'd2, 32'hFFFF_FFFF);
        rd(3'd2, 32'h0, "sig_fold_ones");
        wr(3'd2, 32'h0);
        rd(3'd2, 32'h0, "sig_fold_zero_on_zero");

        // Checkpoints, RO write ignored, unmapped reads, saturation at 4 bits
        do_reset();
        wr(3'd1, 32'h10);
        wr(3'd1, 32'h20);
        wr(3'd1, 32'h30);
        rd(3'd1, 32'd3, "ckpt_cnt_3");
        rd(3'd6, 32'h30, "ckpt_last");
        wr(3'd6, 32'h1234);
        rd(3'd6, 32'h30, "ckpt_last_ro");
        rd(3'd7, 32'h0, "offset7_reads_zero");
        rd(3'd0, 32'h0, "tohost_reads_zero");
        wr(3'd3, 32'h0);
        for (int i = 0; i < 13; i++) wr(3'd1, 32'h100 + i);
        rd(3'd1, 32'd15, "ckpt_cnt_15");
        wr(3'd1, 32'hCAFE);
        rd(3'd1, 32'd15, "ckpt_cnt_saturated");
        rd(3'd6, 32'hCAFE, "ckpt_last_after_sat");

        // Idle watchdog fires on edge 50
        do_reset();
        repeat (49) @(negedge clk);
        chk("wdog_not_yet", {31'h0, test_done}, 32'h0);
        @(negedge clk);
        chk_status("wdog", 1'b1, 1'b0, 31'h7FFF_FFFF, 1'b1);
        rd(3'd3, 32'd50, "cycles_frozen");

        // TOHOST completion on the watchdog edge wins
        do_reset();
        repeat (48) @(negedge clk);
        wr(3'd0, 32'h1);
        chk_status("tohost_beats_wdog", 1'b1, 1'b1, 31'h0, 1'b0);

        // CYCLES clear on the watchdog edge restarts the count
        do_reset();
        repeat (48) @(negedge clk);
        wr(3'd3, 32'h0);
        chk_status("clear_beats_wdog", 1'b0, 1'b0, 31'h0, 1'b0);
        rd(3'd3, 32'd1, "cycles_after_clear");

        // Drain the expectation queue with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL read_drain pending=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
